// File: rtl/pio_led_seq_ctrl.sv
// LED PIO pattern sequencer: an Avalon-MM slave holds mode/period/pattern, and an Avalon-MM
// master pushes each new pattern to the PIO data register at offset 0.
module pio_led_seq_ctrl #(
  parameter int unsigned         WIDTH      = 10,
  parameter int unsigned         PERIOD_W   = 24,
  parameter logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(1000)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [1:0]       m_address,
  output logic [WIDTH-1:0] m_writedata,
  input  logic             m_waitrequest
);

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;
  localparam logic       DIR_LEFT     = 1'b0;
  localparam logic       DIR_RIGHT    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                run_q, run_d;
  logic [1:0]          mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    cur_q, cur_d;
  logic                dir_q, dir_d;
  logic                pending_q, pending_d;
  logic                repush_q, repush_d;
  logic                mcs_q, mcs_d;
  logic                mwn_q, mwn_d;
  logic [WIDTH-1:0]    mwd_q, mwd_d;

  logic                wr_c, wr_ctrl_c, wr_period_c, wr_pat_c;
  logic [PERIOD_W-1:0] term_c;
  logic [WIDTH-1:0]    shl_c, shr_c, step_val_c;
  logic                step_dir_c;
  logic                unused_wdata_c;

  assign wr_c        = chipselect & ~write_n;
  assign wr_ctrl_c   = wr_c && (address == ADDR_CTRL);
  assign wr_period_c = wr_c && (address == ADDR_PERIOD);
  assign wr_pat_c    = wr_c && (address == ADDR_PATTERN);
  assign unused_wdata_c = ^writedata;

  // A period of 0 behaves as 1, so the terminal count never underflows
  assign term_c = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  assign shl_c = {cur_q[WIDTH-2:0], 1'b0};
  assign shr_c = {1'b0, cur_q[WIDTH-1:1]};

  // Next pattern for the current mode; bounce flips direction when a 1 reaches an edge
  always_comb begin
    step_val_c = cur_q;
    step_dir_c = dir_q;
    case (mode_q)
      2'd1: step_val_c = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
      2'd2: begin
        if (dir_q == DIR_LEFT) begin
          step_val_c = shl_c;
          if (shl_c[WIDTH-1]) step_dir_c = DIR_RIGHT;
        end else begin
          step_val_c = shr_c;
          if (shr_c[0]) step_dir_c = DIR_LEFT;
        end
      end
      2'd3: step_val_c = ~cur_q;
      default: step_val_c = cur_q;
    endcase
  end

  // Register writes, sequencing FSM and master strobe generation
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    mode_d    = mode_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    repush_d  = repush_q;
    mcs_d     = mcs_q;
    mwn_d     = mwn_q;
    mwd_d     = mwd_q;

    if (wr_ctrl_c) begin
      run_d  = writedata[0];
      mode_d = writedata[2:1];
    end
    if (wr_period_c) period_d = writedata[PERIOD_W-1:0];
    if (wr_pat_c) begin
      cur_d     = writedata[WIDTH-1:0];
      dir_d     = DIR_LEFT;
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_q || wr_pat_c) begin
          state_d  = ST_PUSH;
          mcs_d    = 1'b1;
          mwn_d    = 1'b0;
          mwd_d    = cur_d;
          repush_d = 1'b0;
        end else if (run_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A slave pattern write pre-empts any step due in the same cycle
        if (pending_q || wr_pat_c) begin
          cnt_d    = '0;
          state_d  = ST_PUSH;
          mcs_d    = 1'b1;
          mwn_d    = 1'b0;
          mwd_d    = cur_d;
          repush_d = 1'b0;
        end else if (!run_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q >= term_c) begin
          cnt_d    = '0;
          cur_d    = step_val_c;
          dir_d    = step_dir_c;
          state_d  = ST_PUSH;
          mcs_d    = 1'b1;
          mwn_d    = 1'b0;
          mwd_d    = step_val_c;
          repush_d = 1'b0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      ST_PUSH: begin
        // A pattern written while the old value is on the bus needs its own push afterwards
        if (wr_pat_c) repush_d = 1'b1;
        if (!m_waitrequest) begin
          mcs_d     = 1'b0;
          mwn_d     = 1'b1;
          pending_d = repush_q | wr_pat_c;
          repush_d  = 1'b0;
          state_d   = run_q ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      mode_q    <= 2'd0;
      period_q  <= PERIOD_RST;
      cnt_q     <= '0;
      cur_q     <= '0;
      dir_q     <= DIR_LEFT;
      pending_q <= 1'b0;
      repush_q  <= 1'b0;
      mcs_q     <= 1'b0;
      mwn_q     <= 1'b1;
      mwd_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      repush_q  <= repush_d;
      mcs_q     <= mcs_d;
      mwn_q     <= mwn_d;
      mwd_q     <= mwd_d;
    end
  end

  // Zero-wait-state read mux, decoded straight from the address
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:    readdata = {29'b0, mode_q, run_q};
      ADDR_PERIOD:  readdata = 32'(period_q);
      ADDR_PATTERN: readdata = 32'(cur_q);
      ADDR_STATUS: begin
        readdata[0]          = (state_q != ST_IDLE);
        readdata[1]          = pending_q;
        readdata[2]          = dir_q;
        readdata[16 +: WIDTH] = cur_q;
      end
      default: readdata = '0;
    endcase
  end

  assign m_chipselect = mcs_q;
  assign m_write_n    = mwn_q;
  assign m_address    = 2'b00;
  assign m_writedata  = mwd_q;

endmodule

// File: tb/tb_pio_led_seq_ctrl.sv
// Bench for pio_led_seq_ctrl: expected master writes are queued by an abstract pattern model
// and compared by an independent bus monitor; directed and random scenarios.
module tb_pio_led_seq_ctrl;
  localparam int unsigned WIDTH    = 10;
  localparam int unsigned PERIOD_W = 24;
  localparam int          MAXV     = 1024;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             m_chipselect;
  logic             m_write_n;
  logic [1:0]       m_address;
  logic [WIDTH-1:0] m_writedata;
  logic             m_waitrequest;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int push_cyc[$];
  int cyc = 0;
  int slen = 0;
  int last_slen = 0;
  int stall_mode = 0;
  int stall_cnt = 0;
  int m_cur = 0;
  int m_mode = 0;
  bit m_dir = 1'b0;

  pio_led_seq_ctrl #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .PERIOD_RST(24'd1000)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_address(m_address),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: every accepted master write is compared with the head of the queue
  always @(negedge clk) begin
    if (!reset_n) slen = 0;
    else if (m_chipselect && !m_write_n) begin
      slen++;
      if (!m_waitrequest) begin
        last_slen = slen;
        slen = 0;
        push_cyc.push_back(cyc);
        chk("push_addr", m_address, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_push actual=0x%0h expected=none", m_writedata);
        end else begin
          chk("push_data", m_writedata, exp_q.pop_front());
        end
      end
    end
  end

  // Fabric stall generator: 0 none, 1 random (max 3 in a row), 2 always, 3 driven by the test
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        0: m_waitrequest = 1'b0;
        1: begin
          if (stall_cnt >= 3 || $urandom_range(0, 2) != 0) begin
            m_waitrequest = 1'b0;
            stall_cnt = 0;
          end else begin
            m_waitrequest = 1'b1;
            stall_cnt++;
          end
        end
        2: m_waitrequest = 1'b1;
        default: ;
      endcase
    end
  end

  // Reference pattern rules in plain arithmetic
  task automatic model_step();
    case (m_mode)
      1: m_cur = (m_cur * 2) % MAXV + m_cur / (MAXV / 2);
      2: begin
        if (!m_dir) begin
          m_cur = (m_cur * 2) % MAXV;
          if (m_cur >= MAXV / 2) m_dir = 1'b1;
        end else begin
          m_cur = m_cur / 2;
          if (m_cur % 2 == 1) m_dir = 1'b0;
        end
      end
      3: m_cur = (MAXV - 1) - m_cur;
      default: ;
    endcase
  endtask

  task automatic expect_steps(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      exp_q.push_back(m_cur);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    address = a;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_q_empty(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] st;
    st = 32'h1;
    for (int i = 0; i < 40; i++) begin
      read_reg(2'd3, st);
      if (!st[0]) break;
    end
    chk(name, st[0], 0);
  endtask

  task automatic stop_by_ctrl(input string name);
    write_reg(2'd0, 32'(m_mode << 1));
    wait_idle(name);
  endtask

  task automatic stop_by_reset(input string name);
    address = 2'd3;
    reset_n = 1'b0;
    #1;
    chk({name, "_cs"}, m_chipselect, 0);
    chk({name, "_status"}, readdata, 0);
    exp_q.delete();
    m_cur = 0;
    m_dir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic load_pattern(input int v, input string name);
    m_cur = v;
    m_dir = 1'b0;
    exp_q.push_back(v);
    write_reg(2'd2, 32'(v));
    wait_q_empty(40, name);
  endtask

  initial begin
    logic [31:0] rd;
    bit found;
    int v, md, pr, ns;
    reset_n = 1'b0;
    address = 2'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    m_waitrequest = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    address = 2'd3; #1 chk("rst_status", readdata, 0);
    address = 2'd1; #1 chk("rst_period", readdata, 1000);
    address = 2'd0; #1 chk("rst_ctrl", readdata, 0);
    chk("rst_m_cs", m_chipselect, 0);
    chk("rst_m_wn", m_write_n, 1);
    chk("rst_m_wd", m_writedata, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Static: one write one cycle later, then silence
    exp_q.push_back(32'h2A5);
    write_reg(2'd2, 32'h2A5);
    @(negedge clk);
    chk("t2_lat_cs", m_chipselect, 1);
    chk("t2_lat_data", m_writedata, 32'h2A5);
    repeat (100) @(posedge clk);
    chk("t2_drain", exp_q.size(), 0);
    wait_idle("t2_idle");

    // Rotate-left with period 4
    load_pattern(32'h201, "t3_load");
    write_reg(2'd1, 32'd4);
    push_cyc.delete();
    m_mode = 1;
    expect_steps(3);
    write_reg(2'd0, 32'h3);
    wait_q_empty(100, "t3_drain");
    chk("t3_count", push_cyc.size(), 3);
    if (push_cyc.size() == 3) begin
      chk("t3_gap1", push_cyc[1] - push_cyc[0], 5);
      chk("t3_gap2", push_cyc[2] - push_cyc[1], 5);
    end
    stop_by_ctrl("t3_idle");

    // Bounce with period 1, across both ends
    load_pattern(1, "t4_load");
    write_reg(2'd1, 32'd1);
    m_mode = 2;
    expect_steps(20);
    write_reg(2'd0, 32'h5);
    wait_q_empty(300, "t4_drain");
    stop_by_reset("t4_rst");

    // Blink with period 0
    load_pattern(32'h3FF, "t6_load");
    write_reg(2'd1, 32'd0);
    m_mode = 3;
    push_cyc.delete();
    expect_steps(6);
    write_reg(2'd0, 32'h7);
    wait_q_empty(100, "t6_drain");
    if (push_cyc.size() >= 3) chk("t6_gap", push_cyc[2] - push_cyc[1], 2);
    stop_by_reset("t6_rst");

    // Shrinking PERIOD below the running count forces an immediate step
    load_pattern(32'h0C3, "pb_load");
    write_reg(2'd1, 32'd50);
    m_mode = 1;
    write_reg(2'd0, 32'h3);
    repeat (20) @(posedge clk);
    expect_steps(2);
    write_reg(2'd1, 32'd5);
    @(posedge clk);
    @(negedge clk);
    chk("pb_step_cs", m_chipselect, 1);
    wait_q_empty(60, "pb_drain");
    stop_by_ctrl("pb_idle");

    // Stalled blink push with a PATTERN write landing in the stall window
    load_pattern(32'h0F0, "t5_load");
    write_reg(2'd1, 32'd8);
    @(negedge clk);
    stall_mode = 3;
    m_waitrequest = 1'b1;
    m_mode = 3;
    expect_steps(1);
    m_cur = 32'h0AA;
    m_dir = 1'b0;
    exp_q.push_back(32'h0AA);
    write_reg(2'd0, 32'h7);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_chipselect) found = 1'b1;
    end
    chk("t5_strobe", found, 1);
    write_reg(2'd2, 32'h0AA);
    address = 2'd3;
    @(negedge clk);
    chk("t5_pending", readdata[1], 1);
    chk("t5_cur", readdata[16 +: WIDTH], 32'h0AA);
    chk("t5_hold_data", m_writedata, 32'h30F);
    chk("t5_hold_cs", m_chipselect, 1);
    @(posedge clk); #1 m_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_strobe_len", last_slen, 4);
    stall_mode = 0;
    wait_q_empty(60, "t5_drain");
    stop_by_ctrl("t5_idle");

    // Reset while a push is stalled on the bus
    @(negedge clk);
    stall_mode = 3;
    m_waitrequest = 1'b1;
    write_reg(2'd2, 32'h155);
    @(negedge clk);
    chk("t1_push_cs", m_chipselect, 1);
    @(posedge clk); #1;
    address = 2'd3;
    reset_n = 1'b0;
    #1;
    chk("t1_rst_cs", m_chipselect, 0);
    chk("t1_rst_wn", m_write_n, 1);
    chk("t1_rst_status", readdata, 0);
    exp_q.delete();
    m_waitrequest = 1'b0;
    stall_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Random idle pattern writes under random stalls
    for (int r = 0; r < 6; r++) begin
      stall_mode = int'($urandom_range(0, 1));
      v = int'($urandom_range(0, MAXV - 1));
      m_cur = v;
      m_dir = 1'b0;
      exp_q.push_back(v);
      write_reg(2'd2, 32'(v));
      @(negedge clk);
      chk("rnd_pat_lat", m_chipselect, 1);
      wait_q_empty(20, "rnd_pat_drain");
    end

    // Random running rounds
    for (int r = 0; r < 10; r++) begin
      stall_mode = int'($urandom_range(0, 1));
      v  = int'($urandom_range(0, MAXV - 1));
      md = int'($urandom_range(0, 3));
      pr = int'($urandom_range(3, 6));
      ns = int'($urandom_range(2, 6));
      load_pattern(v, "rnd_load");
      write_reg(2'd1, 32'(pr));
      m_mode = md;
      expect_steps(ns);
      write_reg(2'd0, 32'((md << 1) | 1));
      wait_q_empty(200, "rnd_drain");
      stop_by_ctrl("rnd_idle");
    end

    stall_mode = 0;
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
